// File: rtl/tx_pwm_pkg.sv
// tx_pwm_pkg: shared mode type and pulse-width helper
// for the TX PWM encoder and its FIFO.
package tx_pwm_pkg;

    typedef enum logic {
        PWM_MODE  = 1'b0,
        EDGE_MODE = 1'b1
    } mode_e;

    // Full 32-bit width so large codes or steps never truncate.
    function automatic logic [31:0] pulse_width(
        input logic [31:0] code,
        input logic [31:0] min_w,
        input logic [31:0] step
    );
        return min_w + code * step;
    endfunction

endpackage

// File: rtl/tx_pwm_fifo.sv
// tx_pwm_fifo: small synchronous FIFO holding symbols
// waiting for their frame slot.
module tx_pwm_fifo
    import tx_pwm_pkg::*;
#(
    parameter int unsigned NBITS = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [NBITS-1:0]       data_i,
    output logic [NBITS-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [NBITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (lvl_q == FULL_LVL);
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/tx_pwm_encoder.sv
// tx_pwm_encoder: one buffered symbol per frame, sent as
// a PWM pulse or as a single edge at a code-set offset.
module tx_pwm_encoder
    import tx_pwm_pkg::*;
#(
    parameter int unsigned NBITS     = 4,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MIN_W     = 2,
    parameter int unsigned FRAME     = 20,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned IDLE_CODE = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   mode,
    input  logic [NBITS-1:0]       s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   underrun_clr,
    output logic                   out,
    output logic                   frame_start,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun
);

    localparam int unsigned FCW = $clog2(FRAME);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME - 1);
    localparam logic [NBITS-1:0] IDLE = NBITS'(IDLE_CODE);

    if (FRAME <= MIN_W + ((2 ** NBITS) - 1) * STEP) begin : g_bad_frame
        $error("FRAME too short for the widest code");
    end

    logic [FCW-1:0]   fc_q, fc_d;
    logic [NBITS-1:0] cur_q, cur_d;
    mode_e            mode_q, mode_d;
    logic             out_q, out_d;
    logic             fs_q, fs_d;
    logic             ur_q, ur_d;

    logic [NBITS-1:0] head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             at_start;
    logic [NBITS-1:0] eff;
    mode_e            mode_eff;
    logic [31:0]      width;
    logic [31:0]      fc_ext;

    tx_pwm_fifo #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (s_valid),
        .pop_i   (pop),
        .data_i  (s_data),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign s_ready     = !full;
    assign out         = out_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

    always_comb begin
        at_start = en && (fc_q == '0);
        pop      = at_start && !empty;
        eff      = cur_q;
        mode_eff = mode_q;
        if (at_start) begin
            eff      = empty ? IDLE : head;
            mode_eff = mode_e'(mode);
        end
        width  = pulse_width(32'(eff), MIN_W, STEP);
        fc_ext = 32'(fc_q);

        fc_d   = fc_q;
        cur_d  = cur_q;
        mode_d = mode_q;
        out_d  = out_q;
        fs_d   = 1'b0;
        ur_d   = ur_q;

        if (underrun_clr) begin
            ur_d = 1'b0;
        end

        if (!en) begin
            fc_d   = '0;
            out_d  = 1'b0;
            mode_d = mode_e'(mode);
        end else begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
            case (mode_eff)
                PWM_MODE:  out_d = (fc_ext < width);
                EDGE_MODE: out_d = out_q ^ (fc_ext == width);
            endcase
            // A fresh underrun outranks a clear in the same cycle.
            if (at_start) begin
                cur_d  = eff;
                mode_d = mode_eff;
                fs_d   = 1'b1;
                if (empty) begin
                    ur_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fc_q   <= '0;
            cur_q  <= IDLE;
            mode_q <= PWM_MODE;
            out_q  <= 1'b0;
            fs_q   <= 1'b0;
            ur_q   <= 1'b0;
        end else begin
            fc_q   <= fc_d;
            cur_q  <= cur_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            fs_q   <= fs_d;
            ur_q   <= ur_d;
        end
    end

endmodule

// File: tb/tb_tx_pwm_encoder.sv
// tb_tx_pwm_encoder: scoreboard bench; stimulus queues
// expected frames, a negedge monitor measures and compares.
module tb_tx_pwm_encoder;

    localparam int FRAME = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       underrun_clr = 1'b0;
    logic       s_ready;
    logic       out;
    logic       frame_start;
    logic [2:0] level;
    logic       underrun;

    typedef struct {
        logic edg;
        int   w;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    int   idx;
    int   ones;
    int   tog;
    int   tpos;
    logic active = 1'b0;
    logic prev = 1'b0;
    logic first;

    always #5 clk = ~clk;

    tx_pwm_encoder dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .mode         (mode),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .underrun_clr (underrun_clr),
        .out          (out),
        .frame_start  (frame_start),
        .level        (level),
        .underrun     (underrun)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d",
                     nm, act, req);
        end
    endtask

    task automatic expect_frame(input logic edg, input int w);
        frame_t f;
        f.edg = edg;
        f.w   = w;
        exp_q.push_back(f);
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic push_sym(input logic [3:0] d);
        chk("push_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic run_frames(input int n, input logic clr);
        en = 1'b1;
        underrun_clr = clr;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        repeat (FRAME * n - 1) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic score();
        frame_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got ones=%0d, want none",
                     ones);
        end else begin
            e = exp_q.pop_front();
            if (!e.edg) begin
                chk("pwm_width", ones, e.w);
                chk("pwm_rise_at_start", first, 1);
            end else begin
                chk("edge_toggles", tog, 1);
                chk("edge_pos", tpos, e.w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            active = 1'b0;
            prev   = 1'b0;
        end else begin
            if (frame_start) begin
                if (active) chk("frame_len", idx, FRAME);
                active = 1'b1;
                idx    = 0;
                ones   = 0;
                tog    = 0;
                tpos   = -1;
                first  = out;
            end
            if (active) begin
                if (out) ones++;
                if (out != prev) begin
                    tog++;
                    tpos = idx;
                end
                idx++;
                if (idx == FRAME) begin
                    active = 1'b0;
                    score();
                end
            end
            prev = out;
        end
    end

    initial begin
        #12;
        chk("rst_out", out, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_fs", frame_start, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // PWM: codes 0, 5, 15
        push_sym(4'd0);
        push_sym(4'd5);
        push_sym(4'd15);
        chk("pwm_level", level, 3);
        expect_frame(1'b0, 2);
        expect_frame(1'b0, 7);
        expect_frame(1'b0, 17);
        run_frames(3, 1'b0);
        chk("pwm_underrun", underrun, 0);
        chk("pwm_level_end", level, 0);

        // Edge position: codes 3, 3, 10
        mode = 1'b1;
        push_sym(4'd3);
        push_sym(4'd3);
        push_sym(4'd10);
        expect_frame(1'b1, 5);
        expect_frame(1'b1, 5);
        expect_frame(1'b1, 12);
        run_frames(3, 1'b0);
        mode = 1'b0;
        chk("edge_out_idle", out, 0);

        // Mid-frame mode switch at fc=8
        push_sym(4'd5);
        push_sym(4'd5);
        expect_frame(1'b0, 7);
        expect_frame(1'b1, 7);
        en = 1'b1;
        repeat (8) @(posedge clk);
        #1 mode = 1'b1;
        repeat (FRAME * 2 - 8) @(posedge clk);
        #1 en = 1'b0;
        mode = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure with en=0
        push_sym(4'd1);
        push_sym(4'd9);
        push_sym(4'd4);
        push_sym(4'd12);
        chk("bp_level_full", level, 4);
        chk("bp_ready_full", s_ready, 0);
        s_valid = 1'b1;
        s_data  = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_level_held", level, 4);
        chk("bp_ready_held", s_ready, 0);
        expect_frame(1'b0, 3);
        expect_frame(1'b0, 11);
        expect_frame(1'b0, 6);
        expect_frame(1'b0, 14);
        expect_frame(1'b0, 9);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after_pop", s_ready, 1);
        chk("bp_level_after_pop", level, 3);
        @(posedge clk);
        #1 s_valid = 1'b0;
        chk("bp_level_refill", level, 4);
        chk("bp_ready_refill", s_ready, 0);
        repeat (FRAME * 5 - 2) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_level_end", level, 0);

        // Underrun: idle frame, sticky, clear, set-wins
        expect_frame(1'b0, 2);
        run_frames(1, 1'b0);
        chk("ur_set", underrun, 1);
        push_sym(4'd6);
        chk("ur_sticky", underrun, 1);
        underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        chk("ur_cleared", underrun, 0);
        expect_frame(1'b0, 8);
        run_frames(1, 1'b0);
        chk("ur_no_event", underrun, 0);
        expect_frame(1'b0, 2);
        run_frames(1, 1'b1);
        chk("ur_set_wins", underrun, 1);

        // Async reset in the middle of a pulse
        push_sym(4'd15);
        push_sym(4'd15);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_out", out, 1);
        #1 rstn = 1'b0;
        #1;
        chk("async_out", out, 0);
        chk("async_level", level, 0);
        chk("async_ready", s_ready, 1);
        chk("async_underrun", underrun, 0);
        en = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        chk("frames_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
